// File: rtl/uart_seq_checker_pkg.sv
// Shared definitions for the UART receive-side sequence checker.
// Holds the checker state encoding and the default parameter values.
package uart_seq_checker_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } seq_state_t;

   localparam int CNT_W_DEFAULT       = 16;
   localparam int RESYNC_ERRS_DEFAULT = 4;

endpackage

// File: rtl/uart_seq_checker_sat_counter.sv
// Saturating up-counter used for the checker statistics.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset, clears q
//   clr     - synchronous clear, has priority over inc
//   inc     - count enable, one increment per cycle while high
//   q       - count value, holds at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/uart_seq_checker.sv
// Sequence checker downstream of uart_rx. Locks onto an incrementing byte
// stream, counts bytes / mismatches / parity errors and strobes error_pulse
// for every offending byte while locked.
//
// state  | meaning
// -------+--------------------------------------------------------------
// HUNT   | waiting for a clean byte to seed the expected value
// LOCKED | comparing each byte against expected; drops back to HUNT after
//        | RESYNC_ERRS consecutive mismatches
//
// Ports:
//   clk, reset_n                    - clock, async active-low reset
//   rx_done, data_received,
//   parity_error                    - byte strobe and payload from uart_rx
//   clear                           - sync clear of counters and state
//   locked, error_pulse             - status and one-cycle error strobe
//   byte_count, err_count,
//   parity_count                    - saturating statistics
//   bad_data, bad_exp               - last mismatching byte and its expectation
module uart_seq_checker
   import uart_seq_checker_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int RESYNC_ERRS = RESYNC_ERRS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rx_done,
   input  logic [7:0]       data_received,
   input  logic             parity_error,
   input  logic             clear,
   output logic             locked,
   output logic             error_pulse,
   output logic [CNT_W-1:0] byte_count,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] parity_count,
   output logic [7:0]       bad_data,
   output logic [7:0]       bad_exp
);

   localparam logic [3:0] RESYNC_LIM = 4'(RESYNC_ERRS);

   seq_state_t state, state_nx;
   logic [7:0] expected, expected_nx;
   logic [3:0] consec, consec_nx, consec_inc;
   logic       pulse_nx;
   logic [7:0] bad_data_nx, bad_exp_nx;
   logic       inc_byte, inc_err, inc_par;

   assign consec_inc = consec + 4'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= HUNT;
         expected    <= 8'h00;
         consec      <= 4'd0;
         error_pulse <= 1'b0;
         bad_data    <= 8'h00;
         bad_exp     <= 8'h00;
      end else begin
         state       <= state_nx;
         expected    <= expected_nx;
         consec      <= consec_nx;
         error_pulse <= pulse_nx;
         bad_data    <= bad_data_nx;
         bad_exp     <= bad_exp_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      expected_nx = expected;
      consec_nx   = consec;
      pulse_nx    = 1'b0;
      bad_data_nx = bad_data;
      bad_exp_nx  = bad_exp;
      inc_byte    = 1'b0;
      inc_err     = 1'b0;
      inc_par     = 1'b0;
      if (clear) begin
         // A byte arriving with clear is dropped entirely.
         state_nx    = HUNT;
         expected_nx = 8'h00;
         consec_nx   = 4'd0;
         bad_data_nx = 8'h00;
         bad_exp_nx  = 8'h00;
      end else if (rx_done) begin
         inc_byte = 1'b1;
         unique case (state)
            HUNT: begin
               if (parity_error) begin
                  inc_par = 1'b1;
               end else begin
                  expected_nx = data_received + 8'd1;
                  consec_nx   = 4'd0;
                  state_nx    = LOCKED;
               end
            end
            LOCKED: begin
               // Every byte advances expected: a corrupted byte is assumed
               // to occupy its slot rather than be inserted or lost.
               expected_nx = expected + 8'd1;
               if (parity_error) begin
                  inc_par  = 1'b1;
                  pulse_nx = 1'b1;
               end else if (data_received == expected) begin
                  consec_nx = 4'd0;
               end else begin
                  inc_err     = 1'b1;
                  pulse_nx    = 1'b1;
                  bad_data_nx = data_received;
                  bad_exp_nx  = expected;
                  if (consec_inc == RESYNC_LIM) begin
                     state_nx  = HUNT;
                     consec_nx = 4'd0;
                  end else begin
                     consec_nx = consec_inc;
                  end
               end
            end
            default: state_nx = HUNT;
         endcase
      end
   end

   assign locked = (state == LOCKED);

   sat_counter #(.W(CNT_W)) u_byte_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear),
      .inc     (inc_byte),
      .q       (byte_count)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear),
      .inc     (inc_err),
      .q       (err_count)
   );

   sat_counter #(.W(CNT_W)) u_par_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear),
      .inc     (inc_par),
      .q       (parity_count)
   );

endmodule

// File: tb/tb_uart_seq_checker.sv
module tb_uart_seq_checker;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_done = 1'b0;
   logic [7:0]  data_received = 8'h00;
   logic        parity_error = 1'b0;
   logic        clear = 1'b0;
   logic        locked;
   logic        error_pulse;
   logic [15:0] byte_count;
   logic [15:0] err_count;
   logic [15:0] parity_count;
   logic [7:0]  bad_data;
   logic [7:0]  bad_exp;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_seq_checker #(.CNT_W(16), .RESYNC_ERRS(4)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rx_done       (rx_done),
      .data_received (data_received),
      .parity_error  (parity_error),
      .clear         (clear),
      .locked        (locked),
      .error_pulse   (error_pulse),
      .byte_count    (byte_count),
      .err_count     (err_count),
      .parity_count  (parity_count),
      .bad_data      (bad_data),
      .bad_exp       (bad_exp)
   );

   typedef struct {
      logic        clr;
      logic        rx;
      logic [7:0]  d;
      logic        par;
      logic        e_lock;
      logic        e_pulse;
      logic [15:0] e_byte;
      logic [15:0] e_err;
      logic [15:0] e_parc;
      logic [7:0]  e_bd;
      logic [7:0]  e_be;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   function automatic vec_t mk(input logic c, input logic r, input logic [7:0] d,
                               input logic p, input logic l, input logic pu,
                               input int b, input int e, input int pc,
                               input logic [7:0] bd, input logic [7:0] be);
      vec_t v;
      v.clr = c; v.rx = r; v.d = d; v.par = p;
      v.e_lock = l; v.e_pulse = pu;
      v.e_byte = 16'(b); v.e_err = 16'(e); v.e_parc = 16'(pc);
      v.e_bd = bd; v.e_be = be;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got 0x%0h, wanted 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_locked"}, 0, int'(locked), 0);
      check({name, "_pulse"},  0, int'(error_pulse), 0);
      check({name, "_bytes"},  0, int'(byte_count), 0);
      check({name, "_errs"},   0, int'(err_count), 0);
      check({name, "_par"},    0, int'(parity_count), 0);
      check({name, "_bd"},     0, int'(bad_data), 0);
      check({name, "_be"},     0, int'(bad_exp), 0);
   endtask

   initial begin
      // clean lock 0x10..0x14
      vecs.push_back(mk(0,1,8'h10,0, 1,0,1,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h11,0, 1,0,2,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h12,0, 1,0,3,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h13,0, 1,0,4,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h14,0, 1,0,5,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,0,8'h00,0, 1,0,5,0,0,8'h00,8'h00));
      vecs.push_back(mk(1,0,8'h00,0, 0,0,0,0,0,8'h00,8'h00));
      // wrap through 0xFF
      vecs.push_back(mk(0,1,8'hFE,0, 1,0,1,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'hFF,0, 1,0,2,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h00,0, 1,0,3,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h01,0, 1,0,4,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h02,0, 1,0,5,0,0,8'h00,8'h00));
      vecs.push_back(mk(1,0,8'h00,0, 0,0,0,0,0,8'h00,8'h00));
      // single corrupted byte
      vecs.push_back(mk(0,1,8'h1F,0, 1,0,1,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h20,0, 1,0,2,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h55,0, 1,1,3,1,0,8'h55,8'h21));
      vecs.push_back(mk(0,1,8'h22,0, 1,0,4,1,0,8'h55,8'h21));
      vecs.push_back(mk(1,0,8'h00,0, 0,0,0,0,0,8'h00,8'h00));
      // four consecutive mismatches drop lock, then relock
      vecs.push_back(mk(0,1,8'h30,0, 1,0,1,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h00,0, 1,1,2,1,0,8'h00,8'h31));
      vecs.push_back(mk(0,1,8'h00,0, 1,1,3,2,0,8'h00,8'h32));
      vecs.push_back(mk(0,1,8'h00,0, 1,1,4,3,0,8'h00,8'h33));
      vecs.push_back(mk(0,1,8'h00,0, 0,1,5,4,0,8'h00,8'h34));
      vecs.push_back(mk(0,1,8'h40,0, 1,0,6,4,0,8'h00,8'h34));
      vecs.push_back(mk(0,1,8'h41,0, 1,0,7,4,0,8'h00,8'h34));
      vecs.push_back(mk(1,0,8'h00,0, 0,0,0,0,0,8'h00,8'h00));
      // parity errors in HUNT and in LOCKED
      vecs.push_back(mk(0,1,8'h77,1, 0,0,1,0,1,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h50,0, 1,0,2,0,1,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h99,1, 1,1,3,0,2,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h52,0, 1,0,4,0,2,8'h00,8'h00));
      // clear coincident with rx_done drops the byte
      vecs.push_back(mk(1,1,8'h53,0, 0,0,0,0,0,8'h00,8'h00));
      vecs.push_back(mk(0,1,8'h60,0, 1,0,1,0,0,8'h00,8'h00));

      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         clear = vecs[i].clr;
         rx_done = vecs[i].rx;
         data_received = vecs[i].d;
         parity_error = vecs[i].par;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty[%0d]: got 0 entries, wanted 1", i);
         end else begin
            vec_t e;
            e = sb.pop_front();
            check("locked", i, int'(locked), int'(e.e_lock));
            check("error_pulse", i, int'(error_pulse), int'(e.e_pulse));
            check("byte_count", i, int'(byte_count), int'(e.e_byte));
            check("err_count", i, int'(err_count), int'(e.e_err));
            check("parity_count", i, int'(parity_count), int'(e.e_parc));
            check("bad_data", i, int'(bad_data), int'(e.e_bd));
            check("bad_exp", i, int'(bad_exp), int'(e.e_be));
         end
      end
      clear = 1'b0; rx_done = 1'b0; parity_error = 1'b0;

      // async reset mid-stream, checked before the next clock edge
      rx_done = 1'b1; data_received = 8'h61;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      check("pre_reset_bytes", 0, int'(byte_count), 2);
      #3;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("after_reset");

      // hold rx_done with parity errors in HUNT until both counters saturate
      rx_done = 1'b1; parity_error = 1'b1; data_received = 8'h00;
      repeat (65540) @(posedge clk);
      #1;
      check("sat_bytes", 0, int'(byte_count), 32'hFFFF);
      check("sat_par", 0, int'(parity_count), 32'hFFFF);
      check("sat_locked", 0, int'(locked), 0);
      check("sat_pulse", 0, int'(error_pulse), 0);
      @(posedge clk);
      #1;
      check("sat_bytes_hold", 0, int'(byte_count), 32'hFFFF);
      rx_done = 1'b0; parity_error = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
